// File: rtl/branch_correct_unit_if.sv
// Handshake bundle between branch resolution (producer), the correction FIFO and fetch (consumer).
// The design attaches through the slave modport and the resolution/fetch side through master.
interface branch_correct_unit_if #(
    parameter int unsigned PC_W = 32
);
    logic            in_valid;
    logic            in_mispredict;
    logic [PC_W-1:0] in_pc;
    logic            in_ready;
    logic            out_valid;
    logic [PC_W-1:0] out_pc;
    logic            out_ready;

    modport master (
        output in_valid, in_mispredict, in_pc, out_ready,
        input  in_ready, out_valid, out_pc
    );

    modport slave (
        input  in_valid, in_mispredict, in_pc, out_ready,
        output in_ready, out_valid, out_pc
    );
endinterface

// File: rtl/branch_correct_unit.sv
// Queues corrected PCs from mispredicted branches for fetch and tracks the mispredict streak.
// Correct predictions break the streak but are not queued.
module branch_correct_unit #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 3,
    parameter int unsigned THRESH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    branch_correct_unit_if.slave     bus,
    output logic [CNT_W-1:0]         o_counter,
    output logic                     o_storm,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [PC_W-1:0]          o_last_pc
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [PC_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [PC_W-1:0]  last_pc_q, last_pc_d;
    logic             accept, push, pop;

    assign bus.in_ready  = (level_q != (AW + 1)'(DEPTH));
    assign bus.out_valid = (level_q != '0);
    assign bus.out_pc    = mem_q[rd_ptr_q];

    assign accept = bus.in_valid & bus.in_ready;
    assign push   = accept & bus.in_mispredict;
    assign pop    = bus.out_valid & bus.out_ready;

    assign o_counter = counter_q;
    assign o_storm   = (counter_q >= CNT_W'(THRESH));
    assign o_level   = level_q;
    assign o_last_pc = last_pc_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        counter_d = counter_q;
        last_pc_d = last_pc_q;

        if (accept) begin
            last_pc_d = bus.in_pc;
            if (bus.in_mispredict) begin
                counter_d = (counter_q == CntMax) ? counter_q : counter_q + CNT_W'(1);
            end else begin
                counter_d = '0;
            end
        end

        // Flush wins over push/pop/increment but still records the accepted PC.
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
            counter_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            counter_q <= '0;
            last_pc_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            counter_q <= counter_d;
            last_pc_q <= last_pc_d;
        end
    end

    // Storage is not reset; validity is tracked by level_q alone.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= bus.in_pc;
        end
    end
endmodule

// File: tb/tb_branch_correct_unit.sv
// Self-checking bench for branch_correct_unit: queue scoreboard of expected correction PCs
// plus a small model of level, streak counter and last accepted PC.
module tb_branch_correct_unit;
    localparam int PC_W   = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;
    localparam int THRESH = 4;
    localparam int CMAX   = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic [CNT_W-1:0]  o_counter;
    logic              o_storm;
    logic [2:0]        o_level;
    logic [PC_W-1:0]   o_last_pc;

    branch_correct_unit_if #(.PC_W(PC_W)) bus ();

    branch_correct_unit #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .THRESH(THRESH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .bus      (bus.slave),
        .o_counter(o_counter),
        .o_storm  (o_storm),
        .o_level  (o_level),
        .o_last_pc(o_last_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [PC_W-1:0] exp_q[$];
    int              m_level = 0;
    int              m_cnt   = 0;
    logic [PC_W-1:0] m_last  = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drives one clock's worth of stimulus; entered shortly after a falling edge.
    task automatic cycle(input logic v, input logic m, input logic [PC_W-1:0] pc,
                         input logic ordy, input logic fl);
        logic acc, pop;
        bus.in_valid      = v;
        bus.in_mispredict = m;
        bus.in_pc         = pc;
        bus.out_ready     = ordy;
        flush             = fl;
        #1;
        check("in_ready", bus.in_ready, m_level != DEPTH);
        check("out_valid", bus.out_valid, m_level != 0);
        if (m_level != 0) check("out_pc", bus.out_pc, exp_q[0]);
        acc = v && (m_level != DEPTH);
        pop = (m_level != 0) && ordy;
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
            m_cnt = 0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc && m) exp_q.push_back(pc);
            if (acc) m_cnt = m ? ((m_cnt == CMAX) ? CMAX : m_cnt + 1) : 0;
        end
        m_level = exp_q.size();
        if (acc) m_last = pc;
        @(negedge clk);
        check("o_counter", o_counter, m_cnt);
        check("o_level", o_level, m_level);
        check("o_storm", o_storm, m_cnt >= THRESH);
        check("o_last_pc", o_last_pc, m_last);
    endtask

    // Asynchronous reset pulse inside one clock phase; outputs checked before the next edge.
    task automatic pulse_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        rst           = 1'b0;
        #2;
        check("rst_counter", o_counter, 0);
        check("rst_level", o_level, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_storm", o_storm, 0);
        check("rst_last_pc", o_last_pc, 0);
        #1;
        rst = 1'b1;
        exp_q.delete();
        m_level = 0;
        m_cnt   = 0;
        m_last  = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && m_level != 0; i++) cycle(0, 0, '0, 1, 0);
        check("drained", o_level, 0);
    endtask

    initial begin
        bus.in_valid      = 1'b0;
        bus.in_mispredict = 1'b0;
        bus.in_pc         = '0;
        bus.out_ready     = 1'b0;
        @(negedge clk);
        pulse_reset();

        // Three mispredicts, fetch stalled; first accept right after reset release.
        cycle(1, 1, 32'h100, 0, 0);
        cycle(1, 1, 32'h200, 0, 0);
        cycle(1, 1, 32'h300, 0, 0);
        check("req037_out_pc", bus.out_pc, 32'h100);
        check("req037_counter", o_counter, 3);

        // Storm threshold and saturation; pops return in order.
        cycle(1, 1, 32'h400, 0, 0);
        check("req038_storm", o_storm, 1);
        for (int i = 0; i < 5; i++) cycle(1, 1, 32'h500 + 32'(i) * 32'h100, 1, 0);
        check("req038_sat", o_counter, CMAX);
        drain();

        // Full FIFO: extra record refused, one pop reopens the input.
        for (int i = 0; i < DEPTH; i++) cycle(1, 1, 32'hA00 + 32'(i), 0, 0);
        check("req039_full", bus.in_ready, 0);
        cycle(1, 1, 32'hBEE, 0, 0);
        cycle(0, 0, '0, 1, 0);
        check("req039_reopen", bus.in_ready, 1);
        drain();

        // Correct prediction breaks the streak without queuing.
        cycle(1, 1, 32'h810, 0, 0);
        cycle(1, 1, 32'h820, 0, 0);
        cycle(1, 0, 32'h880, 0, 0);
        check("req040_cnt", o_counter, 0);
        check("req040_level", o_level, 2);

        // Flush with a coincident accepted mispredict and pop.
        cycle(1, 1, 32'h900, 1, 1);
        check("req041_valid", bus.out_valid, 0);
        check("req041_last", o_last_pc, 32'h900);

        // Mid-operation reset, then a wrap run of simultaneous push/pop.
        for (int i = 0; i < 3; i++) cycle(1, 1, 32'hC00 + 32'(i), 0, 0);
        pulse_reset();
        cycle(1, 1, 32'hD00, 0, 0);
        for (int i = 1; i <= 12; i++) cycle(1, 1, 32'hD00 + 32'(i), 1, 0);
        drain();

        for (int i = 0; i < 60; i++)
            cycle(1'($urandom), ($urandom % 4) != 0, $urandom, 1'($urandom),
                  ($urandom % 16) == 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
